ripple_count_tracker: RTL and testbench
=======================================

Name: ripple_count_tracker

Overview:
- Downstream consumer of the 3-bit ripple (async) up counter output `q`.
- Resynchronises the counter value into the system clock domain and filters ripple intermediate values by stability.
- Checks that every accepted change is a +1 (mod 8) step, and counts wrap-arounds (7->0) and step errors for status and debug.

Parameters:
- STABLE, 2, consecutive edges the synchronised value must hold before it is accepted (range 1..7).
- LOCK_CNT, 2, consecutive good +1 steps required to enter LOCKED (range 1..7).
- WRAP_W, 8, width of `wrap_count`.
- ERR_W, 4, width of `err_count` (saturating).

Ports:
- clk  input  1  system clock; must be faster than the counter's step rate.
- reset  input  1  synchronous, active-high reset.
- q_in  input  3  counter value from the ripple counter; asynchronous to clk.
- clear  input  1  synchronous clear of `wrap_count` and `err_count` only.
- cur_value  output  3  last accepted (filtered) counter value.
- locked  output  1  high while in LOCKED.
- wrap_pulse  output  1  one-cycle pulse on an accepted 7->0 step while LOCKED.
- step_err  output  1  one-cycle pulse on an accepted non-+1 change while LOCKED.
- wrap_count  output  WRAP_W  wraps seen; rolls over modulo 2^WRAP_W.
- err_count  output  ERR_W  errors seen; saturates at all-ones.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Synchroniser: two flops, q_in -> s1 -> s2.
- Stability filter, registers `cand` and `cnt`, evaluated each edge:
  - If s2 != cand: cand<=s2, cnt<=1.
  - Else if cnt<STABLE: cnt<=cnt+1.
- Accept event: on the edge where cnt reaches STABLE (cnt==STABLE-1 and s2==cand), or cnt==STABLE already holds with s2==cand, and cand != cur_value. On that edge cur_value<=cand.
- Latency: a q_in change settled before edge E0 is accepted at edge E(1+STABLE). For STABLE=2 that is the 4th edge; pulses are visible after that edge.
- Glitch rejection: any value held for fewer than STABLE edges in s2 is never accepted.
- FSM states IDLE, ACQUIRE, LOCKED:
  - IDLE (after reset): first value stable for STABLE edges is loaded into cur_value, even if 0 -> ACQUIRE with good=0. No pulses.
  - ACQUIRE: on accept, if cand==cur_value+1 (mod 8) then good++; when good reaches LOCK_CNT -> LOCKED. Otherwise good<=0. No pulses or counts in ACQUIRE.
  - LOCKED: on accept, if cand==cur_value+1 (mod 8): no error; if it is a 7->0 step, wrap_pulse=1 and wrap_count++.
  - LOCKED: on accept, otherwise step_err=1, err_count++ (saturating), -> ACQUIRE with good=0.
- locked=1 exactly while in LOCKED; it changes on the same edge as the transition.
- wrap_pulse and step_err are registered, one cycle wide, and mutually exclusive.
- clear:
  - Zeroes both counters on that edge; clear wins over a coincident increment (result 0).
  - The pulse output still fires; the FSM and filter are unaffected.
- Reset values: s1, s2, cand, cnt, cur_value, good, all counters and outputs = 0; state = IDLE. Reset mid-operation discards all history.
- No accept events (counter stopped): all state holds; no timeout.

Test Plan:
- Reset, then q_in steps 0..7,0,1 every 10 clk (STABLE=2, LOCK_CNT=2) -> locked rises on the 1->2 accept. One wrap_pulse at the 7->0 accept, 4 edges after q_in change. wrap_count=1, err_count=0.
- While LOCKED at 3, q_in goes 011->010->000->100 with each intermediate held 1 clk -> only 3->4 accepted, no step_err, cur_value=4.
- While LOCKED at 2, q_in jumps to 5 -> step_err pulse 1 cycle, err_count=1, locked=0. Steps 6,7 -> locked=1 again; the 7->0 wrap is counted.
- Force 20 errors, each followed by relock -> err_count saturates at 15 (ERR_W=4), no rollover.
- Assert clear on the same edge as a wrap accept with wrap_count=5 -> wrap_pulse=1, wrap_count=0 after the edge.
- Assert reset for 1 cycle while LOCKED at 6 -> all outputs 0, state IDLE. Next stable value 6 loads without a pulse, and lock requires 2 further good steps.

Source files
------------

// File: rtl/ripple_count_tracker.sv
// Resynchronises a free-running 3-bit ripple counter into clk, filters ripple
// intermediates by stability, tracks +1 stepping, and counts wraps and step errors.
module ripple_count_tracker #(
    parameter int STABLE   = 2,
    parameter int LOCK_CNT = 2,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        q_in,
    input  logic              clear,
    output logic [2:0]        cur_value,
    output logic              locked,
    output logic              wrap_pulse,
    output logic              step_err,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [2:0] STABLE_C = 3'(STABLE);
    localparam logic [2:0] LOCK_C   = 3'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [2:0] inc3(input logic [2:0] v);
        return v + 3'd1;
    endfunction

    logic [2:0] s1_r, s2_r, cand_r, cnt_r, good_r, good_nxt_s;
    state_t     state_r, state_nxt_s;
    logic       stable_s, accept_s, is_step_s, wrap_nxt_s, err_nxt_s;

    // The candidate becomes acceptable on the edge its run in s2 reaches STABLE.
    assign stable_s  = (s2_r == cand_r) && (cnt_r >= (STABLE_C - 3'd1));
    assign accept_s  = stable_s && ((state_r == IDLE) || (cand_r != cur_value));
    assign is_step_s = (cand_r == inc3(cur_value));

    // Two-flop synchroniser followed by the run-length stability filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r   <= 3'd0;
            s2_r   <= 3'd0;
            cand_r <= 3'd0;
            cnt_r  <= 3'd0;
        end else begin
            s1_r <= q_in;
            s2_r <= s1_r;
            if (s2_r != cand_r) begin
                cand_r <= s2_r;
                cnt_r  <= 3'd1;
            end else if (cnt_r < STABLE_C) begin
                cnt_r <= cnt_r + 3'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Filtered value register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_value <= 3'd0;
        end else if (accept_s) begin
            cur_value <= cand_r;
        end else begin
            cur_value <= cur_value;
        end
    end

    // FSM state and good-step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            good_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            good_r  <= good_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        good_nxt_s  = good_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ACQUIRE;
                    good_nxt_s  = 3'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACQUIRE: begin
                if (accept_s && is_step_s) begin
                    if ((good_r + 3'd1) >= LOCK_C) begin
                        state_nxt_s = LOCKED;
                        good_nxt_s  = 3'd0;
                    end else begin
                        good_nxt_s = good_r + 3'd1;
                    end
                end else if (accept_s) begin
                    good_nxt_s = 3'd0;
                end else begin
                    good_nxt_s = good_r;
                end
            end
            LOCKED: begin
                if (accept_s && !is_step_s) begin
                    state_nxt_s = ACQUIRE;
                    good_nxt_s  = 3'd0;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                good_nxt_s  = 3'd0;
            end
        endcase
    end

    // Pulse decode; only accepted changes seen while LOCKED produce events.
    always_comb begin
        wrap_nxt_s = 1'b0;
        err_nxt_s  = 1'b0;
        if ((state_r == LOCKED) && accept_s) begin
            if (is_step_s) begin
                wrap_nxt_s = (cand_r == 3'd0);
            end else begin
                err_nxt_s = 1'b1;
            end
        end else begin
            wrap_nxt_s = 1'b0;
            err_nxt_s  = 1'b0;
        end
    end

    // Registered status outputs and counters; clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked     <= 1'b0;
            wrap_pulse <= 1'b0;
            step_err   <= 1'b0;
            wrap_count <= {WRAP_W{1'b0}};
            err_count  <= {ERR_W{1'b0}};
        end else begin
            locked     <= (state_nxt_s == LOCKED);
            wrap_pulse <= wrap_nxt_s;
            step_err   <= err_nxt_s;
            if (clear) begin
                wrap_count <= {WRAP_W{1'b0}};
            end else if (wrap_nxt_s) begin
                wrap_count <= wrap_count + {{(WRAP_W-1){1'b0}}, 1'b1};
            end else begin
                wrap_count <= wrap_count;
            end
            if (clear) begin
                err_count <= {ERR_W{1'b0}};
            end else if (err_nxt_s && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
                err_count <= err_count;
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_tracker.sv
// Randomised bench for ripple_count_tracker against a run-length/event reference model.
module tb_ripple_count_tracker;

    localparam int STABLE   = 2;
    localparam int LOCK_CNT = 2;
    localparam int WRAP_W   = 8;
    localparam int ERR_W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        q_in;
    logic              clear;
    logic [2:0]        cur_value;
    logic              locked, wrap_pulse, step_err;
    logic [WRAP_W-1:0] wrap_count;
    logic [ERR_W-1:0]  err_count;

    int n_chk = 0;
    int n_bad = 0;

    ripple_count_tracker #(.STABLE(STABLE), .LOCK_CNT(LOCK_CNT), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .q_in(q_in), .clear(clear),
        .cur_value(cur_value), .locked(locked), .wrap_pulse(wrap_pulse),
        .step_err(step_err), .wrap_count(wrap_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference model: q_in reaches the filter two edges late; a value is accepted
    // once it has been observed on STABLE consecutive edges.
    int m_d1, m_d2, m_last, m_run, m_cur, m_good, m_wc, m_ec, m_st;
    bit m_lock, m_wp, m_se;
    int q_now;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int v;
        bit held, acc, step;
        if (reset) begin
            m_d1 = 0; m_d2 = 0; m_last = 0; m_run = 0; m_cur = 0; m_good = 0;
            m_wc = 0; m_ec = 0; m_st = 0; m_lock = 0; m_wp = 0; m_se = 0;
            return;
        end
        v = m_d2;
        m_d2 = m_d1;
        m_d1 = int'(q_in);
        held = (v == m_last);
        if (held) m_run = (m_run < STABLE) ? m_run + 1 : STABLE;
        else begin m_last = v; m_run = 1; end
        acc  = held && (m_run >= STABLE) && (m_st == 0 || v != m_cur);
        step = (v == ((m_cur + 1) % 8));
        m_wp = 0; m_se = 0;
        if (acc) begin
            if (m_st == 0) begin
                m_st = 1; m_good = 0;
            end else if (m_st == 1) begin
                if (step) begin
                    m_good++;
                    if (m_good >= LOCK_CNT) m_st = 2;
                end else m_good = 0;
            end else begin
                if (step) m_wp = (m_cur == 7);
                else begin m_se = 1; m_st = 1; m_good = 0; end
            end
            m_cur = v;
        end
        if (m_wp) m_wc = (m_wc + 1) % (1 << WRAP_W);
        if (m_se && m_ec < (1 << ERR_W) - 1) m_ec++;
        if (clear) begin m_wc = 0; m_ec = 0; end
        m_lock = (m_st == 2);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("cur_value", 32'(cur_value), 32'(m_cur));
        chk("locked", 32'(locked), 32'(m_lock));
        chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wp));
        chk("step_err", 32'(step_err), 32'(m_se));
        chk("wrap_count", 32'(wrap_count), 32'(m_wc));
        chk("err_count", 32'(err_count), 32'(m_ec));
    endtask

    task automatic hold_q(input int v, input int n);
        q_now = v % 8;
        q_in  = 3'(q_now);
        repeat (n) tick();
    endtask

    task automatic ramp_to(input int target);
        while (int'(cur_value) != target || !locked) hold_q(q_now + 1, $urandom_range(6, 12));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; q_in = 3'd0; q_now = 0;
        @(negedge clk);
        repeat (3) tick();
        chk("rst_cur", 32'(cur_value), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_wcnt", 32'(wrap_count), 32'd0);
        reset = 1'b0;

        // Clean 0..7,0,1 ramp at a 10-clock step rate.
        for (int i = 0; i <= 9; i++) hold_q(i, 10);
        chk("ramp_locked", 32'(locked), 32'd1);
        chk("ramp_wraps", 32'(wrap_count), 32'd1);
        chk("ramp_errs", 32'(err_count), 32'd0);

        // Ripple intermediates held one clock are rejected.
        ramp_to(3);
        hold_q(2, 1); hold_q(0, 1); hold_q(4, 8);
        chk("glitch_cur", 32'(cur_value), 32'd4);
        chk("glitch_err", 32'(err_count), 32'd0);

        // Step errors followed by relock, enough to saturate err_count.
        for (int e = 0; e < 20; e++) begin
            ramp_to(int'($urandom_range(0, 7)));
            hold_q(q_now + int'($urandom_range(2, 7)), 8);
            chk("err_unlock", 32'(locked), 32'd0);
            hold_q(q_now + 1, 8);
            hold_q(q_now + 1, 8);
        end
        chk("err_sat", 32'(err_count), 32'd15);

        // Clear coincident with a wrap accept: pulse fires, counter ends at zero.
        ramp_to(7);
        q_now = 0; q_in = 3'd0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_wrap_pulse", 32'(wrap_pulse), 32'd1);
        chk("clr_wrap_count", 32'(wrap_count), 32'd0);
        hold_q(q_now, 6);

        // Reset while locked at 6: history discarded, relock needs fresh good steps.
        ramp_to(6);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_rst_locked", 32'(locked), 32'd0);
        hold_q(6, 8);
        chk("mid_rst_cur", 32'(cur_value), 32'd6);
        chk("mid_rst_nolock", 32'(locked), 32'd0);
        hold_q(7, 8);
        hold_q(0, 8);
        chk("mid_rst_relock", 32'(locked), 32'd1);
        chk("mid_rst_wcnt", 32'(wrap_count), 32'd0);

        // Random phase: variable step rates, random glitches, jumps and clears.
        for (int i = 0; i < 300; i++) begin
            clear = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 9))
                0:       hold_q(int'($urandom_range(0, 7)), int'($urandom_range(1, 6)));
                1:       hold_q(int'($urandom_range(0, 7)), 1);
                default: hold_q(q_now + 1, int'($urandom_range(1, 8)));
            endcase
        end
        clear = 1'b0;

        // Stopped counter: everything holds.
        hold_q(q_now, 40);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
